// File: rtl/mac_r4_booth_seq.sv
// ---------------------------------------------------------------------------
// Module   : mac_r4_booth_seq
// Purpose  : Sequential radix-4 Booth multiply-accumulate. One Booth digit is
//            retired per cycle. The finished product is then added into a
//            wide accumulator that has a sticky overflow flag.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mac_r4_booth_seq #(
  parameter int WIDTH = 256,
  parameter int ACC_W = 2*WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  input  logic             acc_clr,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] out,
  output logic             overflow
);

  // The product register is kept 2*WIDTH wide. Every partial-product sum is
  // taken modulo 2^(2*WIDTH), so the bits above that can never reach the
  // exact low half and are not stored.
  localparam int PW    = 2*WIDTH;
  localparam int NDIG  = WIDTH/2 + 1;
  localparam int CNT_W = $clog2(NDIG);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [PW-1:0]    r_prod;
  // The multiplicand moves left by two bits per digit, so the current
  // partial product is always aligned at weight 4^i.
  logic [PW-1:0]    r_mcand;
  // The multiplier window is {ext(B), implicit 0}. It moves right by two bits
  // per digit, so bits [2:0] always hold the current Booth triplet.
  logic [WIDTH+2:0] r_bsh;
  logic             r_sgn;
  logic             r_clr;

  logic [PW-1:0]    w_pp;
  logic             w_neg;
  logic [PW-1:0]    w_psum;
  logic [ACC_W-1:0] w_prod;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W:0]   w_sum;
  logic             w_ovf_now;

  // Booth digit decode: select the magnitude (0, 1x or 2x) and the sign
  always_comb begin
    w_pp  = '0;
    w_neg = 1'b0;
    case (r_bsh[2:0])
      3'b001, 3'b010: w_pp = r_mcand;
      3'b011:         w_pp = {r_mcand[PW-2:0], 1'b0};
      3'b100: begin
        w_pp  = {r_mcand[PW-2:0], 1'b0};
        w_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        w_pp  = r_mcand;
        w_neg = 1'b1;
      end
      default: ;
    endcase
  end

  // Ripple-carry add of the signed partial product. A negative digit is added
  // as the inverted partial product with a carry-in of 1.
  always_comb begin
    logic c;
    logic bb;
    w_psum = '0;
    c      = w_neg;
    for (int k = 0; k < PW; k++) begin
      bb        = w_pp[k] ^ w_neg;
      w_psum[k] = r_prod[k] ^ bb ^ c;
      c         = (r_prod[k] & bb) | (c & (r_prod[k] ^ bb));
    end
  end

  // Extend the product to the accumulator width according to the latched mode
  if (ACC_W > PW) begin : g_ext_wide
    assign w_prod = {{(ACC_W-PW){r_sgn & r_prod[PW-1]}}, r_prod};
  end else begin : g_ext_none
    assign w_prod = r_prod;
  end

  // Accumulate the product and detect overflow for the latched mode
  always_comb begin
    w_base    = r_clr ? '0 : out;
    w_sum     = {1'b0, w_base} + {1'b0, w_prod};
    w_ovf_now = r_sgn ? ((w_base[ACC_W-1] == w_prod[ACC_W-1]) &&
                         (w_sum[ACC_W-1]  != w_base[ACC_W-1]))
                      : w_sum[ACC_W];
  end

  // Control FSM and datapath registers. Everything holds while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_bsh    <= '0;
      r_sgn    <= 1'b0;
      r_clr    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out      <= '0;
      overflow <= 1'b0;
    end else if (en) begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= {{WIDTH{signed_mode & A[WIDTH-1]}}, A};
            r_bsh   <= {{2{signed_mode & B[WIDTH-1]}}, B, 1'b0};
            r_sgn   <= signed_mode;
            r_clr   <= acc_clr;
            r_prod  <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          r_prod  <= w_psum;
          r_mcand <= {r_mcand[PW-3:0], 2'b00};
          r_bsh   <= {2'b00, r_bsh[WIDTH+2:2]};
          if (r_cnt == CNT_W'(NDIG-1)) begin
            r_state <= S_ACC;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_ACC: begin
          out      <= w_sum[ACC_W-1:0];
          overflow <= r_clr ? w_ovf_now : (overflow | w_ovf_now);
          done     <= 1'b1;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mac_r4_booth_seq.sv
// ---------------------------------------------------------------------------
// Module   : tb_mac_r4_booth_seq
// Purpose  : Scoreboard bench for mac_r4_booth_seq with a WIDTH=256 instance
//            and a WIDTH=8 instance, driven by directed vectors.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mac_r4_booth_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         en256, start256, sm256, clr256;
  logic [255:0] a256, b256;
  logic         busy256, done256, ovf256;
  logic [511:0] out256;

  logic         en8, start8, sm8, clr8;
  logic [7:0]   a8, b8;
  logic         busy8, done8, ovf8;
  logic [15:0]  out8;

  int vectors = 0;
  int miscompares = 0;

  logic [512:0] q256[$];
  logic [16:0]  q8[$];

  mac_r4_booth_seq #(.WIDTH(256), .ACC_W(512)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .en(en256), .start(start256),
    .A(a256), .B(b256), .signed_mode(sm256), .acc_clr(clr256),
    .busy(busy256), .done(done256), .out(out256), .overflow(ovf256)
  );

  mac_r4_booth_seq #(.WIDTH(8), .ACC_W(16)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .start(start8),
    .A(a8), .B(b8), .signed_mode(sm8), .acc_clr(clr8),
    .busy(busy8), .done(done8), .out(out8), .overflow(ovf8)
  );

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pop and compare the expected result on each new done pulse
  logic pd8 = 1'b0;
  logic pd256 = 1'b0;
  always @(negedge clk) begin
    logic [16:0]  e8;
    logic [512:0] e256;
    if (done8 === 1'b1 && !pd8) begin
      if (q8.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL done8: got unexpected done pulse, expected none");
      end else begin
        e8 = q8.pop_front();
        chk("out8", {496'd0, out8}, {496'd0, e8[15:0]});
        chk("ovf8", {511'd0, ovf8}, {511'd0, e8[16]});
      end
    end
    if (done256 === 1'b1 && !pd256) begin
      if (q256.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL done256: got unexpected done pulse, expected none");
      end else begin
        e256 = q256.pop_front();
        chk("out256", out256, e256[511:0]);
        chk("ovf256", {511'd0, ovf256}, {511'd0, e256[512]});
      end
    end
    pd8   = (done8 === 1'b1);
    pd256 = (done256 === 1'b1);
  end

  // mode 0: plain; mode 1: en low for 4 cycles mid-MUL;
  // mode 2: second start plus operand changes during MUL
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                      input logic clr, input logic [15:0] eo, input logic eov,
                      input int mode, input int elat);
    int   n;
    logic badb;
    q8.push_back({eov, eo});
    @(negedge clk);
    a8 = a; b8 = b; sm8 = sm; clr8 = clr; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    n = 0;
    badb = 1'b0;
    while (done8 !== 1'b1 && n < 300) begin
      if (busy8 !== 1'b1) badb = 1'b1;
      if (mode == 1 && n == 2) en8 = 1'b0;
      if (mode == 1 && n == 6) en8 = 1'b1;
      if (mode == 2 && n == 3) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; clr8 = 1'b1; sm8 = ~sm;
      end
      if (mode == 2 && n == 4) start8 = 1'b0;
      @(posedge clk);
      #1 n++;
    end
    en8 = 1'b1;
    start8 = 1'b0;
    chk("lat8", 512'(n), 512'(elat));
    chk("busy8_during", {511'd0, badb}, 512'd0);
    chk("busy8_after", {511'd0, busy8}, 512'd0);
  endtask

  task automatic run256(input logic [255:0] a, input logic [255:0] b,
                        input logic clr, input logic [511:0] eo, input logic eov);
    int   n;
    logic badb;
    q256.push_back({eov, eo});
    @(negedge clk);
    a256 = a; b256 = b; sm256 = 1'b0; clr256 = clr; start256 = 1'b1;
    @(posedge clk);
    #1 start256 = 1'b0;
    n = 0;
    badb = 1'b0;
    while (done256 !== 1'b1 && n < 400) begin
      if (busy256 !== 1'b1) badb = 1'b1;
      @(posedge clk);
      #1 n++;
    end
    chk("lat256", 512'(n), 512'd130);
    chk("busy256_during", {511'd0, badb}, 512'd0);
    chk("busy256_after", {511'd0, busy256}, 512'd0);
  endtask

  initial begin
    en256 = 1'b1; start256 = 1'b0; sm256 = 1'b0; clr256 = 1'b0; a256 = '0; b256 = '0;
    en8 = 1'b1; start8 = 1'b0; sm8 = 1'b0; clr8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out8", {496'd0, out8}, 512'd0);
    chk("rst_busy8", {511'd0, busy8}, 512'd0);
    chk("rst_done8", {511'd0, done8}, 512'd0);
    chk("rst_ovf8", {511'd0, ovf8}, 512'd0);
    chk("rst_out256", out256, 512'd0);
    chk("rst_busy256", {511'd0, busy256}, 512'd0);
    chk("rst_done256", {511'd0, done256}, 512'd0);
    chk("rst_ovf256", {511'd0, ovf256}, 512'd0);

    // WIDTH=256 unsigned accumulation chain
    run256(256'd32, 256'd32, 1'b1, 512'd1024, 1'b0);
    run256(256'd5, 256'd10, 1'b0, 512'd1074, 1'b0);
    run256(256'd100, 256'd100, 1'b0, 512'd11074, 1'b0);

    // WIDTH=8 unsigned, including carry-out overflow and its clear
    run8(8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFE01, 1'b0, 0, 6);
    run8(8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFC02, 1'b1, 0, 6);
    run8(8'd2, 8'd3, 1'b0, 1'b1, 16'h0006, 1'b0, 0, 6);
    // WIDTH=8 signed: -3 * 7 = -21
    run8(8'hFD, 8'h07, 1'b1, 1'b1, 16'hFFEB, 1'b0, 0, 6);
    // Ignored second start with changed operands, then a 4-cycle stall
    run8(8'd5, 8'd6, 1'b0, 1'b1, 16'h001E, 1'b0, 2, 6);
    run8(8'd3, 8'd4, 1'b0, 1'b0, 16'h002A, 1'b0, 1, 10);
    // Signed -128 * -128 accumulated twice overflows into the sign bit
    run8(8'h80, 8'h80, 1'b1, 1'b1, 16'h4000, 1'b0, 0, 6);
    run8(8'h80, 8'h80, 1'b1, 1'b0, 16'h8000, 1'b1, 0, 6);

    // Asynchronous reset between edges in the middle of an operation
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd9; sm8 = 1'b0; clr8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out8", {496'd0, out8}, 512'd0);
    chk("arst_busy8", {511'd0, busy8}, 512'd0);
    chk("arst_done8", {511'd0, done8}, 512'd0);
    chk("arst_ovf8", {511'd0, ovf8}, 512'd0);
    @(negedge clk) rst_n = 1'b1;

    // A fresh operation after the reset accumulates from zero
    run8(8'd7, 8'd9, 1'b0, 1'b0, 16'h003F, 1'b0, 0, 6);

    repeat (20) @(posedge clk);
    #1;
    chk("q8_drained", 512'(q8.size()), 512'd0);
    chk("q256_drained", 512'(q256.size()), 512'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mac_r4_booth_seq.md
# mac_r4_booth_seq

Parametrised sequential radix-4 Booth multiply-accumulate unit, the generalised successor of the fixed 256-bit radix-4 ripple-carry MAC. It retires one Booth digit per cycle and adds the finished product into a wide accumulator. Compared with the fixed MAC it adds configurable operand and accumulator widths, a signed/unsigned mode, a start/busy/done handshake, accumulator clear-on-start and a sticky overflow flag. It sits in the arithmetic datapath behind the operand registers, and the controller that sequences multi-operand dot products drives it.

## Interface
- WIDTH, 256: operand width. Must be even and ≥ 4.
- ACC_W, 2*WIDTH: accumulator/output width. Must be ≥ 2*WIDTH.
- clk  in  1  clock. All state changes on the rising edge.
- rst_n  in  1  reset. Asynchronous, active-low.
- en  in  1  clock enable. When low, all registers hold.
- start  in  1  request. Sampled only in IDLE with en=1.
- A  in  WIDTH  multiplicand. Latched at accepted start.
- B  in  WIDTH  multiplier. Latched at accepted start.
- signed_mode  in  1  1 = two's-complement operands. Latched at start.
- acc_clr  in  1  1 = out <= product instead of out + product. Latched at start.
- busy  out  1  high from the edge that accepts start until the edge that writes out.
- done  out  1  one-cycle pulse when out is updated.
- out  out  ACC_W  accumulator.
- overflow  out  1  sticky accumulate overflow.

## Operation
- Reset: FSM=IDLE; out, product register, digit counter, busy, done and overflow all 0.
- FSM states: IDLE → MUL → ACC → IDLE.
  - IDLE: on start=1 and en=1, latch A, B, signed_mode and acc_clr. Clear the product register and set busy=1. Go to MUL.
  - MUL: D = WIDTH/2+1 cycles, one Booth digit per cycle, LSB digit first.
  - ACC: one cycle. Writes out, updates overflow, pulses done, drops busy, returns to IDLE.
- Booth recoding:
  - B is extended to WIDTH+2 bits: sign-extended if signed_mode, zero-extended otherwise. An implicit 0 sits at bit −1.
  - Digit i uses the bits {b[2i+1], b[2i], b[2i−1]} and takes a value in {−2,−1,0,+1,+2}.
  - The partial product is digit × A. A is sign- or zero-extended per mode to 2*WIDTH+2 bits before use.
  - Partial products are shifted by 2i and added into the product register with a ripple-carry adder.
- Product: the low 2*WIDTH bits of the product register are exact in both modes. The product is sign-extended (signed_mode) or zero-extended to ACC_W before the accumulate.
- Accumulate: out <= (acc_clr ? 0 : out) + product, modulo 2^ACC_W.
- Overflow:
  - Unsigned mode: set on carry-out of the ACC_W add.
  - Signed mode: set when both operands have the same sign and the result sign differs.
  - Sticky. Cleared only by reset or by an accumulate with acc_clr=1, which then takes the overflow of product+0, i.e. 0.
- start while busy: ignored. No queueing, no effect on the current operation.
- Inputs A/B/mode changing during MUL have no effect, because the latched copies are used.
- en=0 in any state freezes the FSM, counter, product, out, busy and done. A done pulse that is already high stays high until the next en=1 edge. This stretches latency by one cycle per stalled cycle.
- Reset mid-operation: immediate return to the reset state. The partial result is discarded and out=0.

## Timing
- start accepted at edge 0.
- MUL digits are processed at edges 1..D.
- The ACC write occurs at edge D+1 = WIDTH/2+2. out, done=1 and busy=0 are all visible after that edge.
- Latency is 130 cycles for WIDTH=256 and 6 cycles for WIDTH=8. Each en=0 cycle adds one.
- done is high for exactly one en-qualified cycle.
- The earliest next start is sampled at edge D+2, giving back-to-back throughput of one operation per D+2 cycles.
- out is stable between ACC writes.

## Test plan
- WIDTH=256 default, unsigned:
  - A=32, B=32, acc_clr=1 → out=1024 and done pulse exactly 130 cycles after start, busy high for those cycles.
  - Then A=5, B=10, acc_clr=0 → out=1074.
  - Then A=100, B=100 → out=11074, overflow=0.
- WIDTH=8, ACC_W=16:
  - Unsigned 0xFF×0xFF with acc_clr=1 → out=0xFE01.
  - Repeat with acc_clr=0 → out=0xFC02, overflow=1.
  - Next acc_clr=1 op 2×3 → out=6, overflow=0.
- WIDTH=8 signed:
  - A=0xFD (−3), B=0x07, acc_clr=1 → out=0xFFEB.
  - A=0x80, B=0x80 → 0x4000 accumulated twice gives out=0x8000, overflow=1.
- Handshake:
  - A second start at cycle 3 of a WIDTH=8 op → ignored, single done at cycle 6, out unchanged by the second request.
  - Hold en=0 for 4 cycles mid-MUL → done at cycle 10 with correct result.
- Reset:
  - Assert rst_n=0 asynchronously (between edges) at cycle 3 of an op → out=0, busy=0, done=0 and overflow=0 immediately.
  - A fresh op after release completes normally.
